// File: rtl/fir_pkg.sv
// Shared parameters, types and coefficient table
// for the 8-tap low-pass FIR filter.
package fir_pkg;

   localparam int TAPS      = 8;
   localparam int DATA_W    = 8;
   localparam int COEF_W    = 8;
   localparam int COEF_FRAC = 7;
   localparam int ACC_W     = DATA_W + COEF_W + $clog2(TAPS);

   typedef logic signed [DATA_W-1:0] sample_t;
   typedef logic signed [COEF_W-1:0] coef_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   typedef logic [TAPS-1:0][DATA_W-1:0] dline_t;
   typedef coef_t coef_arr_t [TAPS];

   // Q1.7 taps, newest first; sum is 128 for unity DC gain
   localparam coef_arr_t COEFS = '{
      8'sd2, 8'sd8, 8'sd22, 8'sd32,
      8'sd32, 8'sd22, 8'sd8, 8'sd2
   };

   // Widen one delay-line entry to accumulator width
   function automatic acc_t widen(input logic [DATA_W-1:0] s);
      return acc_t'(signed'(s));
   endfunction

endpackage

// File: rtl/fir_mac.sv
// Combinational multiply-accumulate, round and narrow.
// Define FIR_SATURATE_EN to clamp instead of wrap.
import fir_pkg::*;

module fir_mac (
   input  dline_t  taps_i,
   output sample_t y_o
);

   localparam int RND_W = ACC_W + 1;

   localparam logic signed [RND_W-1:0] HALF =
      RND_W'(1 << (COEF_FRAC - 1));
   localparam logic signed [RND_W-1:0] SAT_MAX =
      RND_W'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [RND_W-1:0] SAT_MIN =
      -RND_W'(1 << (DATA_W - 1));

   acc_t                    acc;
   logic signed [RND_W-1:0] rnd;
   logic signed [RND_W-1:0] shf;

   // Sum of products, then round-half-up and arithmetic shift
   always_comb begin
      acc = '0;
      for (int k = 0; k < TAPS; k++) begin
         acc = acc + widen(taps_i[k]) * acc_t'(COEFS[k]);
      end
      rnd = {acc[ACC_W-1], acc} + HALF;
      shf = rnd >>> COEF_FRAC;
   end

`ifdef FIR_SATURATE_EN
   // Clamp to the representable sample range
   always_comb begin
      if (shf > SAT_MAX) begin
         y_o = sample_t'(SAT_MAX);
      end else if (shf < SAT_MIN) begin
         y_o = sample_t'(SAT_MIN);
      end else begin
         y_o = shf[DATA_W-1:0];
      end
   end
`else
   // Keep the low bits; wraps on overflow
   always_comb begin
      y_o = shf[DATA_W-1:0];
   end

   logic unused_sat;
   assign unused_sat = ^{SAT_MAX, SAT_MIN};
`endif

endmodule

// File: rtl/fir_filter_top.sv
// TinyTapeout wrapper around an 8-tap FIR low-pass:
// delay line, one-stage valid pipe, registered output.
import fir_pkg::*;

module fir_filter_top (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   dline_t  taps_q, taps_d;
   logic    vld_q, vld_d;
   sample_t y_q, y_d;
   logic    rdy_q, rdy_d;
   sample_t mac_y;
   logic    accept;

   assign accept = ena & uio_in[6];

   fir_mac u_mac (
      .taps_i (taps_q),
      .y_o    (mac_y)
   );

   // Next-state: shift on accept, latch result one cycle later
   always_comb begin
      taps_d = taps_q;
      if (accept) begin
         taps_d = {taps_q[TAPS-2:0], ui_in};
      end
      vld_d = accept;
      y_d   = vld_q ? mac_y : y_q;
      rdy_d = vld_q;
   end

   // State registers; reset drops any pending output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taps_q <= '0;
         vld_q  <= 1'b0;
         y_q    <= '0;
         rdy_q  <= 1'b0;
      end else begin
         taps_q <= taps_d;
         vld_q  <= vld_d;
         y_q    <= y_d;
         rdy_q  <= rdy_d;
      end
   end

   assign uo_out  = y_q;
   assign uio_out = {rdy_q, 7'b0};
   assign uio_oe  = 8'b1000_0000;

   logic unused_in;
   assign unused_in = ^{uio_in[7], uio_in[5:0]};

endmodule

// File: tb/tb_fir_filter_top.sv
// Directed bench for fir_filter_top: reset, impulse,
// DC steps, gating, strobe timing, async reset.
module tb_fir_filter_top;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_chk;
   int n_fail;

   fir_filter_top dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got,
                      input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int yv();
      return int'($signed(uo_out));
   endfunction

   function automatic int rv();
      return int'(uio_out[7]);
   endfunction

   // Drive one cycle of inputs, then settle past the edge
   task automatic cyc(input int x, input logic rdy,
                      input logic en);
      ui_in  = 8'(x);
      uio_in = {1'b0, rdy, 6'h15};
      ena    = en;
      @(posedge clk);
      #1;
   endtask

   task automatic run_impulse(input string tag);
      int imp [9] = '{2, 8, 22, 32, 32, 22, 8, 2, 0};
      cyc(127, 1'b1, 1'b1);
      chk({tag, "_first_rdy"}, rv(), 0);
      for (int i = 0; i < 9; i++) begin
         cyc(0, 1'b1, 1'b1);
         chk($sformatf("%s_y%0d", tag, i), yv(), imp[i]);
         chk($sformatf("%s_r%0d", tag, i), rv(), 1);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;

      // Reset with toggling inputs
      for (int i = 0; i < 3; i++) begin
         cyc(i * 37 + 5, 1'b1, 1'b1);
      end
      chk("rst_y", yv(), 0);
      chk("rst_uio_out", int'(uio_out), 0);
      chk("rst_oe", int'(uio_oe), 8'h80);
      @(negedge clk);
      rst_n = 1'b1;
      uio_in = 8'h00;
      @(posedge clk);
      #1;

      run_impulse("imp");

      // Last zero's strobe, then quiet with held output
      cyc(0, 1'b0, 1'b1);
      chk("tail_r", rv(), 1);
      chk("tail_y", yv(), 0);
      cyc(55, 1'b0, 1'b1);
      chk("idle_r", rv(), 0);
      chk("idle_y", yv(), 0);

      // Positive DC step
      for (int i = 0; i < 10; i++) begin
         cyc(100, 1'b1, 1'b1);
         if (i > 0) chk($sformatf("dcp_r%0d", i), rv(), 1);
      end
      chk("dc_pos", yv(), 100);

      // Negative full-scale DC step
      for (int i = 0; i < 10; i++) begin
         cyc(-128, 1'b1, 1'b1);
      end
      chk("dc_neg", yv(), -128);
      chk("dc_neg_r", rv(), 1);

      // ena low: pending strobe completes, then silence
      cyc(50, 1'b1, 1'b0);
      chk("ena_pend_r", rv(), 1);
      chk("ena_pend_y", yv(), -128);
      cyc(50, 1'b1, 1'b0);
      chk("ena_off_r", rv(), 0);
      cyc(50, 1'b1, 1'b0);
      chk("ena_off_y", yv(), -128);

      // input_ready low: no accept
      cyc(60, 1'b0, 1'b1);
      chk("nrdy_r0", rv(), 0);
      cyc(60, 1'b0, 1'b1);
      chk("nrdy_r1", rv(), 0);

      // Delay line untouched: [0, -128 x7] -> -126
      cyc(0, 1'b1, 1'b1);
      chk("resume_r_n", rv(), 0);
      cyc(0, 1'b0, 1'b1);
      chk("resume_y", yv(), -126);
      chk("resume_r", rv(), 1);

      // Async reset between edges while output pending
      cyc(127, 1'b1, 1'b1);
      cyc(0, 1'b1, 1'b1);
      chk("pre_rst_r", rv(), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_r", rv(), 0);
      chk("arst_y", yv(), 0);
      chk("arst_oe", int'(uio_oe), 8'h80);
      uio_in = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_r", rv(), 0);

      run_impulse("imp2");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
